tile_collision_ctrl: RTL and testbench

TILE_COLLISION_CTRL -- requirements
Module: tile_collision_ctrl

---
 rtl/tile_pkg.sv | 49 ++++
 rtl/tile_index_calc.sv | 50 +++++
 rtl/tile_collision_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_tile_collision_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// -----------------------------------------------------------------------------
// tile_pkg
// Shared types and constants for the tile collision controller: tile codes,
// grid geometry, FSM state encoding and the signed screen-coordinate type.
// No ports (package).
// -----------------------------------------------------------------------------
package tile_pkg;

  // Tile codes as returned by the tile map
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SOLID = 2'b01,
    SPIKE = 2'b10,
    GOAL  = 2'b11
  } tile_t;

  localparam int unsigned TILE_W    = 80;
  localparam int unsigned TILE_H    = 80;
  localparam int unsigned GRID_COLS = 8;
  localparam int unsigned GRID_ROWS = 6;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;

  localparam int unsigned IN_COORD_W = 11;
  // One extra bit over the input so corner offsets can never wrap on-screen
  localparam int unsigned COORD_W    = 12;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned TILE_CODE_W = 2;
  localparam int unsigned CORNERS    = 4;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Sign-extend an input coordinate into the internal coordinate width
  function automatic coord_t coord_ext(input logic signed [IN_COORD_W-1:0] c);
    return {c[IN_COORD_W-1], c};
  endfunction

endpackage

// File: rtl/tile_index_calc.sv
// -----------------------------------------------------------------------------
// tile_index_calc
// Converts a signed screen point into tile column/row indices with a
// comparator chain (no divider) and flags points outside the visible screen.
// Ports:
//   pt_i    : point to convert (signed, COORD_W bits per axis)
//   xnum_o  : tile column, 0 when out of range
//   ynum_o  : tile row, 0 when out of range
//   oob_o   : point lies outside 0..SCREEN_W-1 x 0..SCREEN_H-1
// -----------------------------------------------------------------------------
module tile_index_calc
  import tile_pkg::*;
(
  input  point_t           pt_i,
  output logic [IDX_W-1:0] xnum_o,
  output logic [IDX_W-1:0] ynum_o,
  output logic             oob_o
);

  localparam coord_t SCR_W_C = coord_t'(SCREEN_W);
  localparam coord_t SCR_H_C = coord_t'(SCREEN_H);

  logic [IDX_W-1:0] x_idx;
  logic [IDX_W-1:0] y_idx;

  // Range check: sign bit catches negatives, signed compare catches the far edge
  always_comb begin
    oob_o = pt_i.x[COORD_W-1] || (pt_i.x >= SCR_W_C) ||
            pt_i.y[COORD_W-1] || (pt_i.y >= SCR_H_C);
  end

  // floor(coord/80): highest tile boundary not above the coordinate
  always_comb begin
    x_idx = '0;
    for (int unsigned c = 1; c < GRID_COLS; c++) begin
      if (pt_i.x >= coord_t'(c * TILE_W)) x_idx = IDX_W'(c);
    end
  end

  always_comb begin
    y_idx = '0;
    for (int unsigned r = 1; r < GRID_ROWS; r++) begin
      if (pt_i.y >= coord_t'(r * TILE_H)) y_idx = IDX_W'(r);
    end
  end

  assign xnum_o = oob_o ? '0 : x_idx;
  assign ynum_o = oob_o ? '0 : y_idx;

endmodule

// File: rtl/tile_collision_ctrl.sv
// -----------------------------------------------------------------------------
// tile_collision_ctrl
// Probes the four corners of an OBJ_W x OBJ_H object against the tile map,
// one corner per cycle, and reports solid/spike/goal/off-screen hits.
// Build option: define TILE_CENTER_PROBE_EN to add a fifth probe at the
// object centre that drives hit_center; otherwise hit_center is tied to 0.
// Ports:
//   clk, resetN            : clock, asynchronous active-low reset
//   start                  : one-cycle probe request (ignored while busy)
//   topLeftX, topLeftY     : signed object top-left position in pixels
//   Tile_Type              : tile code for the current Xnum/Ynum (combinational)
//   Xnum, Ynum             : tile indices driven to the map during PROBE
//   busy                   : probe sequence in progress (through DONE)
//   done                   : one-cycle pulse, results valid
//   hit_solid[3:0]         : per-corner solid (TL, TR, BL, BR)
//   hit_spike, hit_goal    : any corner on a spike / goal tile
//   out_of_bounds          : any corner off-screen
//   hit_center             : centre tile solid (optional probe)
// -----------------------------------------------------------------------------
module tile_collision_ctrl
  import tile_pkg::*;
#(
  parameter int OBJ_W = 32,
  parameter int OBJ_H = 32
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         start,
  input  logic signed [IN_COORD_W-1:0] topLeftX,
  input  logic signed [IN_COORD_W-1:0] topLeftY,
  input  logic [TILE_CODE_W-1:0]       Tile_Type,
  output logic [IDX_W-1:0]             Xnum,
  output logic [IDX_W-1:0]             Ynum,
  output logic                         busy,
  output logic                         done,
  output logic [CORNERS-1:0]           hit_solid,
  output logic                         hit_spike,
  output logic                         hit_goal,
  output logic                         out_of_bounds,
  output logic                         hit_center
);

`ifdef TILE_CENTER_PROBE_EN
  localparam int unsigned NUM_PROBES = 5;
  localparam coord_t      CTR_X      = coord_t'(OBJ_W / 2);
  localparam coord_t      CTR_Y      = coord_t'(OBJ_H / 2);
`else
  localparam int unsigned NUM_PROBES = 4;
`endif
  localparam int unsigned CNT_W  = 3;
  localparam coord_t      OFF_X  = coord_t'(OBJ_W - 1);
  localparam coord_t      OFF_Y  = coord_t'(OBJ_H - 1);
  localparam logic [CNT_W-1:0] LAST_PROBE = CNT_W'(NUM_PROBES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  coord_t             x_q, x_d;
  coord_t             y_q, y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CORNERS-1:0] solid_q, solid_d;
  logic               spike_q, spike_d;
  logic               goal_q, goal_d;
  logic               oob_q, oob_d;
`ifdef TILE_CENTER_PROBE_EN
  logic               center_q, center_d;
`endif

  point_t           probe_pt;
  logic [IDX_W-1:0] idx_x;
  logic [IDX_W-1:0] idx_y;
  logic             probe_oob;
  tile_t            tile;
  logic             blocked;

  // Current probe point from the latched top-left and the corner counter
  always_comb begin
    probe_pt.x = x_q;
    probe_pt.y = y_q;
    unique case (cnt_q)
      3'd1: probe_pt.x = x_q + OFF_X;
      3'd2: probe_pt.y = y_q + OFF_Y;
      3'd3: begin
        probe_pt.x = x_q + OFF_X;
        probe_pt.y = y_q + OFF_Y;
      end
`ifdef TILE_CENTER_PROBE_EN
      3'd4: begin
        probe_pt.x = x_q + CTR_X;
        probe_pt.y = y_q + CTR_Y;
      end
`endif
      default: ;
    endcase
  end

  tile_index_calc u_index (
    .pt_i   (probe_pt),
    .xnum_o (idx_x),
    .ynum_o (idx_y),
    .oob_o  (probe_oob)
  );

  // Map address is live only while probing
  assign Xnum = (state_q == PROBE) ? idx_x : '0;
  assign Ynum = (state_q == PROBE) ? idx_y : '0;

  // Off-screen counts as solid and never as spike/goal
  assign tile    = tile_t'(Tile_Type);
  assign blocked = probe_oob || (tile == SOLID);

  // Next-state and result accumulation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    solid_d  = solid_q;
    spike_d  = spike_q;
    goal_d   = goal_q;
    oob_d    = oob_q;
`ifdef TILE_CENTER_PROBE_EN
    center_d = center_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PROBE;
          cnt_d    = '0;
          x_d      = coord_ext(topLeftX);
          y_d      = coord_ext(topLeftY);
          solid_d  = '0;
          spike_d  = 1'b0;
          goal_d   = 1'b0;
          oob_d    = 1'b0;
`ifdef TILE_CENTER_PROBE_EN
          center_d = 1'b0;
`endif
        end
      end
      PROBE: begin
        if (cnt_q < CNT_W'(CORNERS)) begin
          solid_d[cnt_q[1:0]] = blocked;
        end
`ifdef TILE_CENTER_PROBE_EN
        else begin
          center_d = blocked;
        end
`endif
        oob_d   = oob_q   | probe_oob;
        spike_d = spike_q | (!probe_oob && (tile == SPIKE));
        goal_d  = goal_q  | (!probe_oob && (tile == GOAL));
        if (cnt_q == LAST_PROBE) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      solid_q  <= '0;
      spike_q  <= 1'b0;
      goal_q   <= 1'b0;
      oob_q    <= 1'b0;
`ifdef TILE_CENTER_PROBE_EN
      center_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      solid_q  <= solid_d;
      spike_q  <= spike_d;
      goal_q   <= goal_d;
      oob_q    <= oob_d;
`ifdef TILE_CENTER_PROBE_EN
      center_q <= center_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign hit_solid     = solid_q;
  assign hit_spike     = spike_q;
  assign hit_goal      = goal_q;
  assign out_of_bounds = oob_q;
`ifdef TILE_CENTER_PROBE_EN
  assign hit_center    = center_q;
`else
  assign hit_center    = 1'b0;
`endif

endmodule

// File: tb/tb_tile_collision_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tile_collision_ctrl
// Directed bench for tile_collision_ctrl with a small behavioural tile map.
// Honours TILE_CENTER_PROBE_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_tile_collision_ctrl;
  import tile_pkg::*;

`ifdef TILE_CENTER_PROBE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic               clk;
  logic               resetN;
  logic               start;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic [1:0]         Tile_Type;
  logic [2:0]         Xnum;
  logic [2:0]         Ynum;
  logic               busy;
  logic               done;
  logic [3:0]         hit_solid;
  logic               hit_spike;
  logic               hit_goal;
  logic               out_of_bounds;
  logic               hit_center;

  logic [1:0] tmap [0:5][0:7];

  int n_cmp  = 0;
  int n_fail = 0;

  tile_collision_ctrl #(.OBJ_W(32), .OBJ_H(32)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .start         (start),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .Tile_Type     (Tile_Type),
    .Xnum          (Xnum),
    .Ynum          (Ynum),
    .busy          (busy),
    .done          (done),
    .hit_solid     (hit_solid),
    .hit_spike     (hit_spike),
    .hit_goal      (hit_goal),
    .out_of_bounds (out_of_bounds),
    .hit_center    (hit_center)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural tile map, read combinationally like the real one
  assign Tile_Type = (Ynum < 3'd6) ? tmap[Ynum][Xnum] : 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] solid, input logic spike,
                           input logic goal, input logic oob, input logic center);
    chk({tag, ".hit_solid"}, 32'(hit_solid), 32'(solid));
    chk({tag, ".hit_spike"}, 32'(hit_spike), 32'(spike));
    chk({tag, ".hit_goal"}, 32'(hit_goal), 32'(goal));
    chk({tag, ".oob"}, 32'(out_of_bounds), 32'(oob));
    chk({tag, ".hit_center"}, 32'(hit_center), 32'(center));
  endtask

  // Accept one start, then watch 12 cycles; optional extra start at cycle restart_at
  task automatic run_probe(input int x, input int y, input int restart_at,
                           output int lat, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    topLeftX = 11'(x);
    topLeftY = 11'(y);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == restart_at + 1) start = 1'b0;
      if (n == restart_at) begin
        start    = 1'b1;
        topLeftX = 11'(300);
        topLeftY = 11'(400);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = n;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bcnt, dcnt;
    resetN   = 1'b0;
    start    = 1'b0;
    topLeftX = '0;
    topLeftY = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        tmap[r][c] = 2'b00;
    for (int c = 0; c <= 5; c++) tmap[5][c] = 2'b01;
    for (int c = 2; c <= 6; c++) tmap[4][c] = 2'b01;
    tmap[0][4] = 2'b11;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.xnum", 32'(Xnum), 32'd0);
    chk("rst.ynum", 32'(Ynum), 32'd0);
    chk_flags("rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    resetN = 1'b1;

    // Object straddling row 4 / row 5 at column 1: bottom corners on solid
    run_probe(100, 370, 0, lat, bcnt, dcnt);
    chk("t1.latency", 32'(lat), 32'(LAT));
    chk("t1.busy_cycles", 32'(bcnt), 32'(LAT));
    chk("t1.done_pulses", 32'(dcnt), 32'd1);
    chk_flags("t1", 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);

    // Open area
    run_probe(10, 10, 0, lat, bcnt, dcnt);
    chk("t2.busy_cycles", 32'(bcnt), 32'(LAT));
    chk("t2.done_pulses", 32'(dcnt), 32'd1);
    chk_flags("t2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Left edge off-screen: TL and BL count as solid
    run_probe(-5, 10, 0, lat, bcnt, dcnt);
    chk("t3.latency", 32'(lat), 32'(LAT));
    chk_flags("t3", 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0);

    // Right edge off-screen, second start while busy must be ignored
    run_probe(620, 10, 2, lat, bcnt, dcnt);
    chk("t4.latency", 32'(lat), 32'(LAT));
    chk("t4.done_pulses", 32'(dcnt), 32'd1);
    chk("t4.busy_cycles", 32'(bcnt), 32'(LAT));
    chk_flags("t4", 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);

    // Entirely inside the goal tile (4,0)
    run_probe(330, 10, 0, lat, bcnt, dcnt);
    chk_flags("t5", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Last pixel inside the screen on both axes
    run_probe(608, 448, 0, lat, bcnt, dcnt);
    chk_flags("t6", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // One pixel further: TR, BL, BR fall off-screen
    run_probe(609, 449, 0, lat, bcnt, dcnt);
    chk_flags("t7", 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a probe sequence
    @(negedge clk);
    topLeftX = 11'(100);
    topLeftY = 11'(370);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t8.xnum_bl", 32'(Xnum), 32'd1);
    chk("t8.ynum_bl", 32'(Ynum), 32'd5);
    resetN = 1'b0;
    #1;
    chk("t8.busy", 32'(busy), 32'd0);
    chk("t8.done", 32'(done), 32'd0);
    chk("t8.xnum", 32'(Xnum), 32'd0);
    chk("t8.ynum", 32'(Ynum), 32'd0);
    chk_flags("t8", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    dcnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    resetN = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("t8.no_done", 32'(dcnt), 32'd0);
    chk("t8.idle_busy", 32'(busy), 32'd0);

    run_probe(10, 10, 0, lat, bcnt, dcnt);
    chk("t9.latency", 32'(lat), 32'(LAT));
    chk("t9.done_pulses", 32'(dcnt), 32'd1);
    chk_flags("t9", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Spike tile at column 2, row 4
    tmap[4][2] = 2'b10;
    run_probe(170, 330, 0, lat, bcnt, dcnt);
    chk("t10.latency", 32'(lat), 32'(LAT));
    chk_flags("t10", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
